led_mux_scheduler: RTL and testbench

Round-robin scheduler that shares the board's 8-bit LED 4:1 output mux between four requesters. It sits in front of the `mux_2` select input in `main`. Each requester gets exclusive use of the LEDs for a programmable dwell time, and the scheduler drives the mux select code and per-requester grant lines. Requesters are typically button/switch-driven sources; the block replaces direct `sw[0:1]` selection.

---
 rtl/led_mux_scheduler.sv | 119 +++++++++++
 tb/tb_led_mux_scheduler.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/led_mux_scheduler.sv
// Round-robin scheduler sharing the 8-bit LED output mux between four
// requesters, each owning the LEDs for a programmable dwell time.
module led_mux_scheduler #(
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [3:0]         req,
    input  logic [DWELL_W-1:0] dwell,
    input  logic               hold,
    output logic [1:0]         sel,
    output logic [3:0]         gnt,
    output logic               busy,
    output logic               done
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t             state, state_n;
    logic [1:0]         ptr, ptr_n;
    logic [DWELL_W-1:0] cnt, cnt_n;
    logic [1:0]         sel_n;
    logic [3:0]         gnt_n;
    logic               busy_n;
    logic               done_n;

    logic [DWELL_W-1:0] dwell_eff;
    logic [1:0]         next_ptr;
    logic [2:0]         win_idle;
    logic [2:0]         win_rel;
    logic               own;
    logic               release_now;

    // Bit 2 flags a winner; bits 1:0 hold its index. Scanning from the far
    // end lets the closest set bit to start overwrite the others.
    function automatic logic [2:0] pick(input logic [3:0] r,
                                        input logic [1:0] start);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int i = 3; i >= 0; i--) begin
            idx = start + 2'(i);
            if (r[idx]) res = {1'b1, idx};
        end
        return res;
    endfunction

    assign dwell_eff   = (dwell == '0) ? DWELL_W'(1) : dwell;
    assign next_ptr    = sel + 2'd1;
    assign win_idle    = pick(req, ptr);
    assign win_rel     = pick(req, next_ptr);
    assign own         = req[sel];
    assign release_now = !own || (cnt == DWELL_W'(1) && !hold);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            ptr   <= 2'd0;
            cnt   <= '0;
            sel   <= 2'd0;
            gnt   <= 4'd0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_n;
            ptr   <= ptr_n;
            cnt   <= cnt_n;
            sel   <= sel_n;
            gnt   <= gnt_n;
            busy  <= busy_n;
            done  <= done_n;
        end
    end

    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        cnt_n   = cnt;
        sel_n   = sel;
        gnt_n   = gnt;
        busy_n  = busy;
        done_n  = 1'b0;
        unique case (state)
            IDLE: begin
                gnt_n  = 4'd0;
                busy_n = 1'b0;
                if (win_idle[2]) begin
                    sel_n   = win_idle[1:0];
                    gnt_n   = 4'b0001 << win_idle[1:0];
                    busy_n  = 1'b1;
                    cnt_n   = dwell_eff;
                    state_n = GRANT;
                end
            end
            GRANT: begin
                if (release_now) begin
                    done_n = 1'b1;
                    ptr_n  = next_ptr;
                    if (win_rel[2]) begin
                        sel_n = win_rel[1:0];
                        gnt_n = 4'b0001 << win_rel[1:0];
                        cnt_n = dwell_eff;
                    end else begin
                        gnt_n   = 4'd0;
                        busy_n  = 1'b0;
                        state_n = IDLE;
                    end
                end else if (!hold) begin
                    cnt_n = cnt - DWELL_W'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_led_mux_scheduler.sv
// Scoreboard bench: a driver steps a cycle-level reference model and queues
// the expected outputs; a monitor pops and compares after each clock edge.
module tb_led_mux_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic [7:0] dwell;
    logic       hold;
    logic [1:0] sel;
    logic [3:0] gnt;
    logic       busy;
    logic       done;

    led_mux_scheduler #(.DWELL_W(8)) dut (
        .clk  (clk),
        .rst  (rst),
        .req  (req),
        .dwell(dwell),
        .hold (hold),
        .sel  (sel),
        .gnt  (gnt),
        .busy (busy),
        .done (done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] sel;
        logic [3:0] gnt;
        logic       busy;
        logic       done;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   passed = 0;
    bit   stop_mon = 0;

    // Reference model: who owns the LEDs and how many cycles remain
    int m_owner = -1;
    int m_left  = 0;
    int m_ptr   = 0;
    int m_sel   = 0;
    bit m_done  = 0;

    function automatic int first_req(input logic [3:0] r, input int start);
        for (int k = 0; k < 4; k++)
            if (r[(start + k) % 4]) return (start + k) % 4;
        return -1;
    endfunction

    function automatic int eff(input logic [7:0] d);
        return (d == 0) ? 1 : int'(d);
    endfunction

    task automatic model_step(input logic [3:0] r, input logic [7:0] d,
                              input logic h, input logic rs);
        int w;
        if (rs) begin
            m_owner = -1; m_left = 0; m_ptr = 0; m_sel = 0; m_done = 0;
            return;
        end
        m_done = 0;
        if (m_owner < 0) begin
            w = first_req(r, m_ptr);
            if (w >= 0) begin
                m_owner = w; m_sel = w; m_left = eff(d);
            end
        end else if (!r[m_owner] || (m_left == 1 && !h)) begin
            m_done = 1;
            m_ptr  = (m_owner + 1) % 4;
            w = first_req(r, m_ptr);
            if (w >= 0) begin
                m_owner = w; m_sel = w; m_left = eff(d);
            end else begin
                m_owner = -1;
            end
        end else if (!h) begin
            m_left--;
        end
    endtask

    task automatic cyc(input logic [3:0] r, input logic [7:0] d,
                       input logic h, input logic rs);
        exp_t e;
        rst = rs; req = r; dwell = d; hold = h;
        model_step(r, d, h, rs);
        e.sel  = 2'(m_sel);
        e.gnt  = (m_owner < 0) ? 4'd0 : (4'b0001 << m_owner);
        e.busy = (m_owner >= 0);
        e.done = m_done;
        q.push_back(e);
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got == want) passed++;
        else $display("FAIL %s: got %0h want %0h at %0t", name, got, want, $time);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (stop_mon) break;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("sel",  int'(sel),  int'(e.sel));
                chk("gnt",  int'(gnt),  int'(e.gnt));
                chk("busy", int'(busy), int'(e.busy));
                chk("done", int'(done), int'(e.done));
            end
        end
    end

    initial begin : driver
        logic [3:0] r;
        logic [7:0] d;
        logic       h;
        logic       rs;
        rst = 1'b1; req = 4'd0; dwell = 8'd0; hold = 1'b0;
        cyc(4'd0, 8'd0, 1'b0, 1'b1);
        cyc(4'd0, 8'd0, 1'b0, 1'b1);
        // single requester, dwell 3, re-granted with no gap
        repeat (10) cyc(4'b0001, 8'd3, 1'b0, 1'b0);
        cyc(4'd0, 8'd0, 1'b0, 1'b1);
        // all requesting, dwell 2: order 0,1,2,3,0
        repeat (11) cyc(4'b1111, 8'd2, 1'b0, 1'b0);
        cyc(4'd0, 8'd0, 1'b0, 1'b1);
        // owner 0 drops early
        cyc(4'b0101, 8'd4, 1'b0, 1'b0);
        cyc(4'b0101, 8'd4, 1'b0, 1'b0);
        repeat (6) cyc(4'b0100, 8'd4, 1'b0, 1'b0);
        cyc(4'd0, 8'd0, 1'b0, 1'b1);
        // owner 2 with hold, then drop during hold
        repeat (5) cyc(4'b0100, 8'd2, 1'b1, 1'b0);
        repeat (4) cyc(4'b0100, 8'd2, 1'b0, 1'b0);
        cyc(4'd0, 8'd0, 1'b0, 1'b1);
        repeat (3) cyc(4'b0100, 8'd5, 1'b1, 1'b0);
        cyc(4'b0000, 8'd5, 1'b1, 1'b0);
        cyc(4'b0000, 8'd5, 1'b0, 1'b0);
        cyc(4'd0, 8'd0, 1'b0, 1'b1);
        // dwell 0 behaves as 1; sel retained when idle
        repeat (3) cyc(4'b0010, 8'd0, 1'b0, 1'b0);
        repeat (3) cyc(4'b0000, 8'd0, 1'b0, 1'b0);
        // reset mid-grant then ptr restarts at 0
        repeat (3) cyc(4'b1000, 8'd6, 1'b0, 1'b0);
        cyc(4'b1000, 8'd6, 1'b0, 1'b1);
        repeat (4) cyc(4'b1001, 8'd2, 1'b0, 1'b0);
        // long dwell boundary
        repeat (3) cyc(4'b0010, 8'd255, 1'b0, 1'b0);
        cyc(4'd0, 8'd0, 1'b0, 1'b1);
        // randomized traffic
        r = 4'd0;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 3) == 0) r = 4'($urandom);
            d  = 8'($urandom_range(0, 5));
            h  = ($urandom_range(0, 4) == 0);
            rs = ($urandom_range(0, 199) == 0);
            cyc(r, d, h, rs);
        end
        repeat (3) @(posedge clk);
        #3;
        stop_mon = 1;
        chk("queue_drained", q.size(), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
